// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter built from toggle stages, with clamped load,
// terminal count and registered wrap pulse. Optional Gray output: MOD_UPDOWN_COUNTER_GRAY_EN.
module mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             s_reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] toggle_s;
    logic             wrap_next_s;

    // Next-state selection: load (clamped) over count over hold.
    always_comb begin
        next_s      = q_r;
        wrap_next_s = 1'b0;
        if (load) begin
            if (d > MAX_VAL) begin
                next_s = MAX_VAL;
            end else begin
                next_s = d;
            end
        end else if (en) begin
            if (up) begin
                if (q_r == MAX_VAL) begin
                    next_s      = ZERO_VAL;
                    wrap_next_s = 1'b1;
                end else begin
                    next_s = q_r + ONE_VAL;
                end
            end else begin
                if (q_r == ZERO_VAL) begin
                    next_s      = MAX_VAL;
                    wrap_next_s = 1'b1;
                end else begin
                    next_s = q_r - ONE_VAL;
                end
            end
        end else begin
            next_s = q_r;
        end
    end

    // Each bit is a T stage: it toggles wherever the next value differs.
    assign toggle_s = q_r ^ next_s;

    // Count register and wrap pulse, synchronous reset.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            q_r    <= ZERO_VAL;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_r ^ toggle_s;
            wrap_r <= wrap_next_s;
        end
    end

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    logic [WIDTH-1:0] q_gray_r;

    // Gray code of the value q takes on the same edge.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            q_gray_r <= ZERO_VAL;
        end else begin
            q_gray_r <= bin2gray(next_s);
        end
    end

    assign q_gray = q_gray_r;
`endif

    assign q    = q_r;
    assign wrap = wrap_r;
    // Gated by en so it can drive the enable of a following stage.
    assign tc   = en & ((up & (q_r == MAX_VAL)) | (~up & (q_r == ZERO_VAL)));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (modulus 10 and a modulus-16 cascade).
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Modulus-10 counter
    logic       a_rst, a_en, a_up, a_load;
    logic [3:0] a_d, a_q;
    logic       a_tc, a_wrap;

    // Modulus-16 cascade: c1 advances on c0 terminal count
    logic       c_rst, c0_en;
    logic [3:0] c0_q, c1_q;
    logic       c0_tc, c1_tc, c0_wrap, c1_wrap;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    logic [3:0] a_gray, c0_gray, c1_gray;
    logic [3:0] gray_tbl [16];
    logic [3:0] prev_gray;
    logic [3:0] diff;
`endif

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_a (
        .clk(clk), .s_reset(a_rst), .en(a_en), .up(a_up), .load(a_load),
        .d(a_d), .q(a_q), .tc(a_tc), .wrap(a_wrap)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .q_gray(a_gray)
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_c0 (
        .clk(clk), .s_reset(c_rst), .en(c0_en), .up(1'b1), .load(1'b0),
        .d(4'd0), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .q_gray(c0_gray)
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_c1 (
        .clk(clk), .s_reset(c_rst), .en(c0_tc), .up(1'b1), .load(1'b0),
        .d(4'd0), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .q_gray(c1_gray)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_d = 4'd0;
        c_rst = 1'b1; c0_en = 1'b0;
        tick();
        check_val("reset_q", a_q, 0);
        check_val("reset_wrap", a_wrap, 0);
        check_val("reset_tc", a_tc, 0);
        check_val("reset_c1_q", c1_q, 0);

        // Count to 7 then reset with en and load also high
        a_rst = 1'b0; a_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check_val("count_to_7", a_q, 7);
        a_rst = 1'b1; a_load = 1'b1; a_d = 4'd5;
        tick();
        check_val("reset_prio_q", a_q, 0);
        check_val("reset_prio_wrap", a_wrap, 0);
        a_rst = 1'b0; a_load = 1'b0;

        // Up run through the wrap
        check_val("up_tc_q0", a_tc, 0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            check_val("up_q", a_q, i % 10);
            check_val("up_wrap", a_wrap, (i == 10) ? 1 : 0);
            check_val("up_tc", a_tc, ((i % 10) == 9) ? 1 : 0);
        end

        // Down from 1 through the wrap
        a_up = 1'b0; #1;
        check_val("dn_tc_q1", a_tc, 0);
        tick();
        check_val("dn_q0", a_q, 0);
        check_val("dn_tc_q0", a_tc, 1);
        check_val("dn_wrap0", a_wrap, 0);
        tick();
        check_val("dn_q9", a_q, 9);
        check_val("dn_wrap9", a_wrap, 1);
        tick();
        check_val("dn_q8", a_q, 8);
        check_val("dn_wrap8", a_wrap, 0);

        // Clamped load, then load beats en at the terminal value
        a_en = 1'b0; a_load = 1'b1; a_d = 4'd12;
        tick();
        check_val("load_clamp", a_q, 9);
        check_val("load_wrap", a_wrap, 0);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1; #1;
        check_val("tc_at_9", a_tc, 1);
        a_load = 1'b1; a_d = 4'd3;
        tick();
        check_val("load_over_en", a_q, 3);
        check_val("load_over_en_wrap", a_wrap, 0);
        a_load = 1'b0; a_en = 1'b0;
        tick();
        check_val("hold_q", a_q, 3);
        check_val("hold_tc", a_tc, 0);

        // Exact max load, then consecutive wraps via direction toggle
        a_load = 1'b1; a_d = 4'd9;
        tick();
        check_val("load_max", a_q, 9);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
        tick();
        check_val("toggle_q0", a_q, 0);
        check_val("toggle_wrap0", a_wrap, 1);
        a_up = 1'b0;
        tick();
        check_val("toggle_q9", a_q, 9);
        check_val("toggle_wrap9", a_wrap, 1);

        // Reset at a wrapping edge discards the wrap
        a_up = 1'b1; a_rst = 1'b1;
        tick();
        check_val("midreset_q", a_q, 0);
        check_val("midreset_wrap", a_wrap, 0);
        a_rst = 1'b0; a_en = 1'b0;

        // Full-modulus cascade over 256 cycles
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        gray_tbl = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                     4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        check_val("gray_reset", c0_gray, 0);
        prev_gray = c0_gray;
`endif
        c_rst = 1'b0; c0_en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if ((i % 16) == 0) begin
                check_val("casc_c0", c0_q, 0);
                check_val("casc_c0_wrap", c0_wrap, 1);
                check_val("casc_c1", c1_q, (i / 16) % 16);
            end else if ((i % 16) == 15) begin
                check_val("casc_c1_pre", c1_q, (i / 16) % 16);
            end
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
            if (i <= 16) begin
                check_val("gray_val", c0_gray, gray_tbl[i % 16]);
                diff = c0_gray ^ prev_gray;
                check_val("gray_1bit", $countones(diff), 1);
                prev_gray = c0_gray;
            end
`endif
        end
        check_val("casc_end_c0", c0_q, 0);
        check_val("casc_end_c1", c1_q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
